// File: rtl/vr_wheel_gen_pkg.sv
// vr_wheel_gen_pkg: shared types, default widths and the config check for the trigger-wheel emulator.
package vr_wheel_gen_pkg;

    localparam int PW_DEF = 24;
    localparam int TW_DEF = 8;

    typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} state_e;

    // Callers zero-extend to 32 bits so one function serves any PW/TW up to 32.
    function automatic logic cfg_valid(input logic [31:0] per, input logic [31:0] dty,
                                       input logic [31:0] tooth, input logic [31:0] miss);
        return per != 0 && dty != 0 && dty < per && miss < tooth && tooth != 0;
    endfunction

endpackage

// File: rtl/vr_gen_slot_timer.sv
// vr_gen_slot_timer: slot cycle counter with clear/load and end-of-high / end-of-slot strobes.
module vr_gen_slot_timer #(
    parameter int PW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          ld_i,
    input  logic [PW-1:0] ld_val_i,
    input  logic [PW-1:0] duty_i,
    input  logic [PW-1:0] period_i,
    output logic          duty_hit_o,
    output logic          per_hit_o
);

    logic [PW-1:0] cnt_q, cnt_d;

    assign cnt_d      = clr_i ? '0 : ld_i ? ld_val_i : cnt_q + 1'b1;
    assign duty_hit_o = cnt_q == duty_i - 1'b1;
    assign per_hit_o  = cnt_q == period_i - 1'b1;

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;

endmodule

// File: rtl/vr_wheel_gen.sv
// vr_wheel_gen: N-M trigger-wheel emulator with revolution marker and slot index.
// Define VR_WHEEL_GEN_ACCEL_EN to add per-revolution period stepping via accel_step.
module vr_wheel_gen
    import vr_wheel_gen_pkg::*;
#(
    parameter int PW = PW_DEF,
    parameter int TW = TW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic [TW-1:0] tooth_num,
    input  logic [TW-1:0] miss_num,
    input  logic [PW-1:0] period,
    input  logic [PW-1:0] duty,
`ifdef VR_WHEEL_GEN_ACCEL_EN
    input  logic signed [PW-1:0] accel_step,
`endif
    output logic          vr_out,
    output logic [TW-1:0] slot_idx,
    output logic          rev_pulse,
    output logic          cfg_err
);

    state_e        state_q, state_d;
    logic [TW-1:0] slot_q, slot_d, tooth_q, tooth_d, miss_q, miss_d;
    logic [TW-1:0] nxt, tooth_n, miss_n;
    logic [PW-1:0] per_q, per_d, duty_q, duty_d, per_n;
    logic          vr_q, vr_d, rev_q, rev_d, err_q, err_d;
    logic          clr, ld, duty_hit, per_hit, wrap, gap, ok_n, ok_idle;

`ifdef VR_WHEEL_GEN_ACCEL_EN
    logic signed [PW+1:0] acc_sum;
    logic        [PW+1:0] acc_lo;
    logic        [PW-1:0] acc_per;

    // Sum kept two bits wider so both underflow and overflow are visible before clamping.
    always_comb begin
        acc_sum = $signed({2'b00, per_q}) + $signed({{2{accel_step[PW-1]}}, accel_step});
        acc_lo  = {2'b00, duty} + 1'b1;
        acc_per = (acc_sum[PW+1] || acc_sum < $signed(acc_lo)) ? acc_lo[PW-1:0] :
                  acc_sum[PW] ? '1 : acc_sum[PW-1:0];
    end
`endif

    always_comb begin
        nxt     = slot_q + 1'b1;
        wrap    = nxt == tooth_q;
        gap     = !wrap && nxt >= tooth_q - miss_q;
        tooth_n = wrap ? tooth_num : tooth_q;
        miss_n  = wrap ? miss_num : miss_q;
`ifdef VR_WHEEL_GEN_ACCEL_EN
        per_n   = wrap ? acc_per : per_q;
`else
        per_n   = period;
`endif
        ok_n    = cfg_valid(32'(per_n), 32'(duty), 32'(tooth_n), 32'(miss_n));
        ok_idle = cfg_valid(32'(period), 32'(duty), 32'(tooth_num), 32'(miss_num));
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        vr_d    = vr_q;
        rev_d   = 1'b0;
        err_d   = err_q;
        per_d   = per_q;
        duty_d  = duty_q;
        tooth_d = tooth_q;
        miss_d  = miss_q;
        clr     = 1'b0;
        ld      = 1'b0;
        if (!ena) begin
            state_d = IDLE;
            slot_d  = '0;
            vr_d    = 1'b0;
            err_d   = 1'b0;
            clr     = 1'b1;
        end else if (state_q == IDLE) begin
            clr   = 1'b1;
            err_d = !ok_idle;
            if (ok_idle) begin
                state_d = HIGH;
                vr_d    = 1'b1;
                rev_d   = 1'b1;
                slot_d  = '0;
                per_d   = period;
                duty_d  = duty;
                tooth_d = tooth_num;
                miss_d  = miss_num;
            end
        end else if (per_hit) begin
            if (!ok_n) begin
                state_d = IDLE;
                slot_d  = '0;
                vr_d    = 1'b0;
                err_d   = 1'b1;
                clr     = 1'b1;
            end else begin
                state_d = gap ? GAP : HIGH;
                vr_d    = !gap;
                rev_d   = wrap;
                slot_d  = wrap ? '0 : nxt;
                ld      = 1'b1;
                per_d   = per_n;
                duty_d  = duty;
                tooth_d = tooth_n;
                miss_d  = miss_n;
            end
        end else if (state_q == HIGH && duty_hit) begin
            state_d = LOW;
            vr_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            slot_q  <= '0;
            vr_q    <= 1'b0;
            rev_q   <= 1'b0;
            err_q   <= 1'b0;
            per_q   <= '0;
            duty_q  <= '0;
            tooth_q <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            vr_q    <= vr_d;
            rev_q   <= rev_d;
            err_q   <= err_d;
            per_q   <= per_d;
            duty_q  <= duty_d;
            tooth_q <= tooth_d;
            miss_q  <= miss_d;
        end

    vr_gen_slot_timer #(.PW(PW)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (clr),
        .ld_i      (ld),
        .ld_val_i  ('0),
        .duty_i    (duty_q),
        .period_i  (per_q),
        .duty_hit_o(duty_hit),
        .per_hit_o (per_hit)
    );

    assign vr_out    = vr_q;
    assign slot_idx  = slot_q;
    assign rev_pulse = rev_q;
    assign cfg_err   = err_q;

endmodule

// File: tb/tb_vr_wheel_gen.sv
// tb_vr_wheel_gen: directed checks of the wheel emulator (default build, no acceleration).
module tb_vr_wheel_gen;

    localparam int PW = 24;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rst, ena;
    logic [TW-1:0] tooth_num, miss_num, slot_idx;
    logic [PW-1:0] period, duty;
    logic          vr_out, rev_pulse, cfg_err;
    int            n_vec = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    vr_wheel_gen #(.PW(PW), .TW(TW)) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .tooth_num(tooth_num),
        .miss_num (miss_num),
        .period   (period),
        .duty     (duty),
        .vr_out   (vr_out),
        .slot_idx (slot_idx),
        .rev_pulse(rev_pulse),
        .cfg_err  (cfg_err)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cfg(input int t, input int m, input int p, input int d);
        tooth_num = TW'(t);
        miss_num  = TW'(m);
        period    = PW'(p);
        duty      = PW'(d);
    endtask

    initial begin
        int rises = 0, highs = 0, revs = 0, last_rise = -1;
        int max_sp = 0, min_sp = 1000000, rev0 = -1, rev1 = -1;
        logic prev = 1'b0;
        rst = 1'b1;
        ena = 1'b0;
        cfg(60, 2, 100, 50);
        step(2);
        chk("rst_vr", vr_out, 0);
        chk("rst_slot", slot_idx, 0);
        chk("rst_rev", rev_pulse, 0);
        chk("rst_err", cfg_err, 0);
        rst = 1'b0;
        step(1);
        // 60-2 wheel over two full revolutions
        ena = 1'b1;
        step(1);
        for (int i = 0; i < 12000; i++) begin
            if (i == 0) begin
                chk("a_vr0", vr_out, 1);
                chk("a_rev0", rev_pulse, 1);
                chk("a_slot0", slot_idx, 0);
            end
            if (i == 49) chk("a_vr49", vr_out, 1);
            if (i == 50) chk("a_vr50", vr_out, 0);
            if (i == 5850) begin
                chk("a_slot58", slot_idx, 58);
                chk("a_gap_vr", vr_out, 0);
            end
            if (i == 5999) chk("a_slot59", slot_idx, 59);
            if (vr_out && !prev) begin
                rises++;
                if (last_rise >= 0) begin
                    if (i - last_rise > max_sp) max_sp = i - last_rise;
                    if (i - last_rise < min_sp) min_sp = i - last_rise;
                end
                last_rise = i;
            end
            highs += int'(vr_out);
            if (rev_pulse) begin
                revs++;
                if (rev0 < 0) rev0 = i;
                else if (rev1 < 0) rev1 = i;
            end
            prev = vr_out;
            step(1);
        end
        chk("a_rises", rises, 116);
        chk("a_highs", highs, 5800);
        chk("a_revs", revs, 2);
        chk("a_rev_per", rev1 - rev0, 6000);
        chk("a_min_sp", min_sp, 100);
        chk("a_gap_sp", max_sp, 300);
        // drop ena in slot 30 while high, then restart
        step(3020);
        chk("b_slot30", slot_idx, 30);
        chk("b_vr_hi", vr_out, 1);
        ena = 1'b0;
        step(1);
        chk("b_off_vr", vr_out, 0);
        chk("b_off_slot", slot_idx, 0);
        chk("b_off_rev", rev_pulse, 0);
        step(3);
        chk("b_idle_vr", vr_out, 0);
        ena = 1'b1;
        step(1);
        chk("b_re_vr", vr_out, 1);
        chk("b_re_rev", rev_pulse, 1);
        chk("b_re_slot", slot_idx, 0);
        step(49);
        chk("b_re_vr49", vr_out, 1);
        step(1);
        chk("b_re_vr50", vr_out, 0);
        // period 100 -> 200 mid-slot
        period = PW'(200);
        step(49);
        chk("c_slot0_end", slot_idx, 0);
        step(1);
        chk("c_slot1", slot_idx, 1);
        chk("c_slot1_vr", vr_out, 1);
        step(199);
        chk("c_slot1_end", slot_idx, 1);
        chk("c_slot1_lo", vr_out, 0);
        step(1);
        chk("c_slot2", slot_idx, 2);
        // invalid configurations from IDLE
        ena = 1'b0;
        step(1);
        cfg(60, 2, 100, 0);
        ena = 1'b1;
        step(1);
        chk("d_duty0_err", cfg_err, 1);
        chk("d_duty0_vr", vr_out, 0);
        step(5);
        chk("d_hold_err", cfg_err, 1);
        chk("d_hold_vr", vr_out, 0);
        chk("d_hold_slot", slot_idx, 0);
        cfg(60, 2, 100, 100);
        step(1);
        chk("d_dutyp_err", cfg_err, 1);
        cfg(60, 60, 100, 50);
        step(1);
        chk("d_miss_err", cfg_err, 1);
        chk("d_miss_vr", vr_out, 0);
        ena = 1'b0;
        step(1);
        chk("d_ena_clr", cfg_err, 0);
        ena = 1'b1;
        step(1);
        chk("d_again_err", cfg_err, 1);
        cfg(4, 1, 10, 3);
        step(1);
        chk("d_fix_err", cfg_err, 0);
        chk("d_fix_vr", vr_out, 1);
        chk("d_fix_rev", rev_pulse, 1);
        // small 4-1 wheel, then switch to 4-0
        step(30);
        chk("e_gap_slot", slot_idx, 3);
        chk("e_gap_vr", vr_out, 0);
        step(10);
        chk("e_wrap_slot", slot_idx, 0);
        chk("e_wrap_rev", rev_pulse, 1);
        cfg(4, 0, 10, 3);
        step(40);
        chk("e_wrap2_rev", rev_pulse, 1);
        step(30);
        chk("e_nomiss_slot", slot_idx, 3);
        chk("e_nomiss_vr", vr_out, 1);
        step(10);
        chk("e_nomiss_rev", rev_pulse, 1);
        // invalid duty arriving while running
        step(5);
        duty = '0;
        step(4);
        chk("f_pre_err", cfg_err, 0);
        step(1);
        chk("f_err", cfg_err, 1);
        chk("f_vr", vr_out, 0);
        chk("f_slot", slot_idx, 0);
        duty = PW'(3);
        step(1);
        chk("f_fix_err", cfg_err, 0);
        chk("f_fix_rev", rev_pulse, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
